// File: rtl/glb_strm_f2g_packer.sv
// glb_strm_f2g_packer: packs per-channel CGRA words into bank words and arbitrates them onto one GLB write port
module glb_strm_f2g_packer #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 16,
  parameter int PACK = 4,
  parameter int CNT_W = 16,
  parameter int ADDR_W = CNT_W,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int BW = PACK * DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     strm_start_pulse,
  input  logic [CNT_W-1:0]         cfg_num_words,
  input  logic [NUM_CH-1:0]        cfg_ch_en,
  input  logic [NUM_CH*DATA_W-1:0] data_f2g,
  input  logic [NUM_CH-1:0]        data_valid_f2g,
  output logic                     wr_en,
  input  logic                     wr_ready,
  output logic [CH_W-1:0]          wr_ch,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [BW-1:0]            wr_data,
  output logic [PACK-1:0]          wr_strb,
  output logic                     busy,
  output logic                     strm_f2g_interrupt,
  output logic                     overflow_err
);
  localparam int SLOT_W = PACK > 1 ? $clog2(PACK) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] num_words;
  logic [NUM_CH-1:0] ch_en, take, cmpl, acc, load, pend_v, pend_nxt, fin;
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [SLOT_W-1:0] slot [NUM_CH];
  logic [ADDR_W-1:0] addr [NUM_CH], pa_n [NUM_CH], pend_addr [NUM_CH];
  logic [BW-1:0] pack [NUM_CH], pk_n [NUM_CH], pd_n [NUM_CH], pend_data [NUM_CH];
  logic [PACK-1:0] strb [NUM_CH], st_n [NUM_CH], ps_n [NUM_CH], pend_strb [NUM_CH];
  logic [CH_W-1:0] last_g, gnt, idx;
  logic found, start, degen;
  assign start = state == IDLE && strm_start_pulse;
  assign degen = cfg_num_words == '0 || cfg_ch_en == '0;
  // A completing pack may refill its pending slot in the same cycle the old entry is accepted
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      take[c] = state == RUN && ch_en[c] && cnt[c] < num_words && data_valid_f2g[c];
      cmpl[c] = take[c] && (slot[c] == SLOT_W'(PACK - 1) || cnt[c] + CNT_W'(1) == num_words);
      acc[c] = wr_en && wr_ready && wr_ch == CH_W'(c);
      load[c] = cmpl[c] && (!pend_v[c] || acc[c]);
      fin[c] = !ch_en[c] || cnt[c] == num_words;
      for (int k = 0; k < PACK; k++) begin
        pk_n[c][k*DATA_W +: DATA_W] = slot[c] == SLOT_W'(k) ? data_f2g[c*DATA_W +: DATA_W] : pack[c][k*DATA_W +: DATA_W];
        st_n[c][k] = strb[c][k] | (slot[c] == SLOT_W'(k));
      end
      pd_n[c] = load[c] ? pk_n[c] : pend_data[c];
      ps_n[c] = load[c] ? st_n[c] : pend_strb[c];
      pa_n[c] = load[c] ? addr[c] : pend_addr[c];
    end
    pend_nxt = (pend_v & ~acc) | load;
  end
  always_comb begin
    gnt = last_g;
    found = 1'b0;
    idx = last_g;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = idx == CH_W'(NUM_CH - 1) ? '0 : idx + CH_W'(1);
      if (!found && pend_nxt[idx]) begin
        gnt = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      num_words <= '0;
      ch_en <= '0;
      pend_v <= '0;
      last_g <= CH_W'(NUM_CH - 1);
      wr_en <= 1'b0;
      wr_ch <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      busy <= 1'b0;
      strm_f2g_interrupt <= 1'b0;
      overflow_err <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        cnt[c] <= '0;
        slot[c] <= '0;
        addr[c] <= '0;
        pack[c] <= '0;
        strb[c] <= '0;
        pend_data[c] <= '0;
        pend_strb[c] <= '0;
        pend_addr[c] <= '0;
      end
    end else begin
      pend_v <= pend_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        pend_data[c] <= pd_n[c];
        pend_strb[c] <= ps_n[c];
        pend_addr[c] <= pa_n[c];
        if (start) begin
          cnt[c] <= '0;
          slot[c] <= '0;
          addr[c] <= '0;
          pack[c] <= '0;
          strb[c] <= '0;
        end else if (take[c]) begin
          cnt[c] <= cnt[c] + CNT_W'(1);
          slot[c] <= cmpl[c] ? '0 : slot[c] + SLOT_W'(1);
          pack[c] <= cmpl[c] ? '0 : pk_n[c];
          strb[c] <= cmpl[c] ? '0 : st_n[c];
          addr[c] <= cmpl[c] ? addr[c] + ADDR_W'(1) : addr[c];
        end
      end
      if (!wr_en || wr_ready) begin
        wr_en <= |pend_nxt;
        if (|pend_nxt) begin
          wr_ch <= gnt;
          last_g <= gnt;
          wr_addr <= pa_n[gnt];
          wr_data <= pd_n[gnt];
          wr_strb <= ps_n[gnt];
        end
      end
      if (|(cmpl & pend_v & ~acc)) overflow_err <= 1'b1;
      case (state)
        IDLE: if (strm_start_pulse) begin
          num_words <= cfg_num_words;
          ch_en <= cfg_ch_en;
          overflow_err <= 1'b0;
          busy <= 1'b1;
          state <= degen ? DONE : RUN;
          strm_f2g_interrupt <= degen;
        end
        RUN: if (&fin) state <= DRAIN;
        DRAIN: if (pend_v == '0) begin
          state <= DONE;
          strm_f2g_interrupt <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
          strm_f2g_interrupt <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_glb_strm_f2g_packer.sv
// tb_glb_strm_f2g_packer: directed vector bench for the f2g packer with a write-content reference model
module tb_glb_strm_f2g_packer;
  logic clk = 1'b0, reset = 1'b1, strm_start_pulse = 1'b0, wr_ready = 1'b1;
  logic [15:0] cfg_num_words = '0;
  logic [3:0] cfg_ch_en = '0, data_valid_f2g = '0;
  logic [63:0] data_f2g = '0;
  logic wr_en, busy, strm_f2g_interrupt, overflow_err;
  logic [1:0] wr_ch;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic [3:0] wr_strb;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  glb_strm_f2g_packer dut (
    .clk(clk), .reset(reset), .strm_start_pulse(strm_start_pulse),
    .cfg_num_words(cfg_num_words), .cfg_ch_en(cfg_ch_en),
    .data_f2g(data_f2g), .data_valid_f2g(data_valid_f2g),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .busy(busy),
    .strm_f2g_interrupt(strm_f2g_interrupt), .overflow_err(overflow_err)
  );

  // rdy: 0 always ready, 1 ready on odd cycles, 2 stalled through cycle 16
  typedef struct {
    logic [3:0] en;
    int num;
    bit gap;
    int rdy;
    logic [3:0] vm;
    int restart;
    int exp_wr;
    bit exp_ovf;
    int exp_intr;
    bit rr;
  } vec_t;
  vec_t vecs[9];

  function automatic logic [15:0] wd(input int c, input int s, input int i);
    return {4'(c), 4'(s), 8'(i)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run(input vec_t v, input int salt);
    int idx[4];
    int nxt[4];
    int nwr = 0, nint = 0, intr_it = -1, n;
    bit stall = 1'b0, done = 1'b0;
    logic [1:0] s_ch;
    logic [15:0] s_addr;
    logic [63:0] s_data, m, e;
    logic [3:0] s_strb, es;
    for (int c = 0; c < 4; c++) begin
      idx[c] = 0;
      nxt[c] = 0;
    end
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
    cfg_num_words = 16'(v.num);
    cfg_ch_en = v.en;
    strm_start_pulse = 1'b1;
    wr_ready = v.rdy != 2;
    data_valid_f2g = 4'hF;
    data_f2g = {4{16'hdead}};
    for (int it = 1; it < 200 && !done; it++) begin
      @(posedge clk); #1;
      strm_start_pulse = it == v.restart;
      if (stall) begin
        chk("stall_wr_en", wr_en, 1);
        chk("stall_wr_ch", wr_ch, s_ch);
        chk("stall_wr_addr", wr_addr, s_addr);
        chk("stall_wr_data", wr_data, s_data);
        chk("stall_wr_strb", wr_strb, s_strb);
      end
      chk("busy_run", busy, 1);
      if (strm_f2g_interrupt) begin
        nint++;
        intr_it = it;
        done = 1'b1;
      end
      wr_ready = v.rdy == 0 || (v.rdy == 1 && it % 2 == 1) || (v.rdy == 2 && it > 16);
      if (wr_en && wr_ready) begin
        n = v.num - 4 * int'(wr_addr);
        if (n > 4) n = 4;
        es = '0;
        e = '0;
        m = '0;
        for (int k = 0; k < 4; k++) if (k < n) begin
          es[k] = 1'b1;
          e[k*16 +: 16] = wd(int'(wr_ch), salt, 4 * int'(wr_addr) + k);
          m[k*16 +: 16] = 16'hffff;
        end
        chk("wr_ch_enabled", v.en[wr_ch], 1);
        chk("wr_addr", wr_addr, nxt[wr_ch]);
        chk("wr_strb", wr_strb, es);
        chk("wr_data", wr_data & m, e);
        if (v.rr) chk("rr_order", wr_ch, nwr % 4);
        nxt[wr_ch]++;
        nwr++;
      end
      stall = wr_en && !wr_ready;
      s_ch = wr_ch;
      s_addr = wr_addr;
      s_data = wr_data;
      s_strb = wr_strb;
      data_valid_f2g = '0;
      data_f2g = '0;
      if (!done && (!v.gap || it % 2 == 1))
        for (int c = 0; c < 4; c++) if (v.vm[c]) begin
          data_valid_f2g[c] = 1'b1;
          data_f2g[c*16 +: 16] = wd(c, salt, idx[c]);
          idx[c]++;
        end
    end
    strm_start_pulse = 1'b0;
    data_valid_f2g = '0;
    wr_ready = 1'b1;
    chk("intr_count", nint, 1);
    if (v.exp_intr > 0) chk("intr_cycle", intr_it, v.exp_intr);
    chk("writes", nwr, v.exp_wr);
    chk("overflow", overflow_err, v.exp_ovf);
    @(posedge clk); #1;
    chk("intr_one_cycle", strm_f2g_interrupt, 0);
    chk("busy_end", busy, 0);
    chk("wr_en_end", wr_en, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_ch"}, wr_ch, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_wr_strb"}, wr_strb, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_intr"}, strm_f2g_interrupt, 0);
    chk({tag, "_ovf"}, overflow_err, 0);
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{4'hF,  8, 1'b0, 0, 4'hF, 0, 8, 1'b0, 14, 1'b1};
    vecs[1] = '{4'h1,  6, 1'b0, 0, 4'h1, 0, 2, 1'b0,  9, 1'b0};
    vecs[2] = '{4'h1, 12, 1'b0, 2, 4'h1, 0, 1, 1'b1, 19, 1'b0};
    vecs[3] = '{4'h2, 10, 1'b0, 1, 4'h2, 0, 3, 1'b0,  0, 1'b0};
    vecs[4] = '{4'h8,  3, 1'b0, 0, 4'hF, 2, 1, 1'b0,  6, 1'b0};
    vecs[5] = '{4'hF,  1, 1'b0, 0, 4'hF, 0, 4, 1'b0,  7, 1'b0};
    vecs[6] = '{4'h0,  5, 1'b0, 0, 4'hF, 0, 0, 1'b0,  1, 1'b0};
    vecs[7] = '{4'hF,  0, 1'b0, 0, 4'hF, 0, 0, 1'b0,  1, 1'b0};
    vecs[8] = '{4'h3,  4, 1'b1, 0, 4'h3, 0, 2, 1'b0,  0, 1'b0};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_zero("reset");
    for (int i = 0; i < 9; i++) run(vecs[i], i + 1);
    // Reset in the middle of a stalled stream, then a fresh stream
    @(posedge clk); #1;
    cfg_num_words = 16'd8;
    cfg_ch_en = 4'h1;
    strm_start_pulse = 1'b1;
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      strm_start_pulse = 1'b0;
      data_valid_f2g = 4'h1;
      data_f2g = {48'h0, wd(0, 9, i)};
    end
    @(posedge clk); #1;
    chk("pre_reset_wr_en", wr_en, 1);
    chk("pre_reset_busy", busy, 1);
    data_valid_f2g = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_zero("midrun_reset");
    reset = 1'b0;
    wr_ready = 1'b1;
    rv = '{4'h1, 4, 1'b0, 0, 4'h1, 0, 1, 1'b0, 7, 1'b0};
    run(rv, 10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
